// File: rtl/mem_burst_writer_if.sv
// mem_burst_writer_if
// Groups the two streaming sides of the burst writer.
//   s00_* : upstream beat stream (data, byte strobes, valid/ready)
//   m00_* : memory write port (enable, address, data, strobes,
//           valid/ready, last-beat marker)
// Modports:
//   master : the burst writer itself (drives s00_axis_tready and all m00 beat outputs)
//   slave  : the environment (upstream source and memory write port)
interface mem_burst_writer_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0]   s00_axis_tdata;
  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb;
  logic                    s00_axis_tvalid;
  logic                    s00_axis_tready;

  logic                    m00_axis_wr_en;
  logic [ADDR_WIDTH-1:0]   m00_axis_wr_addr;
  logic [DATA_WIDTH-1:0]   m00_axis_wr_tdata;
  logic [DATA_WIDTH/8-1:0] m00_axis_tstrb;
  logic                    m00_axis_tvalid;
  logic                    m00_axis_tlast;
  logic                    m00_axis_tready;

  modport master (
    input  s00_axis_tdata, s00_axis_tstrb, s00_axis_tvalid, m00_axis_tready,
    output s00_axis_tready, m00_axis_wr_en, m00_axis_wr_addr, m00_axis_wr_tdata,
           m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast
  );

  modport slave (
    output s00_axis_tdata, s00_axis_tstrb, s00_axis_tvalid, m00_axis_tready,
    input  s00_axis_tready, m00_axis_wr_en, m00_axis_wr_addr, m00_axis_wr_tdata,
           m00_axis_tstrb, m00_axis_tvalid, m00_axis_tlast
  );
endinterface

// File: rtl/mem_burst_writer.sv
// mem_burst_writer
// Takes a burst request (base address + beat count), pulls exactly that
// many beats from the upstream stream and writes them to consecutive
// memory addresses through a single registered output slot.
// Ports:
//   m00_axis_aclk     : clock, rising edge
//   m00_axis_aresetn  : asynchronous active-low reset
//   start             : one-cycle burst request, honoured only when idle
//   base_addr         : first write address, captured with start
//   burst_len         : number of beats, captured with start (0 is rejected)
//   busy              : burst in progress (RUN or DONE)
//   done              : one-cycle pulse after the final beat is written
//   err               : one-cycle pulse when a start request is rejected
//   bus               : upstream stream and memory write port (master side)
// Configuration:
//   MEM_BURST_WRITER_ADDR_WRAP_EN defined   -> addresses wrap modulo 2^ADDR_WIDTH,
//                                              every nonzero burst_len is accepted
//   MEM_BURST_WRITER_ADDR_WRAP_EN undefined -> bursts running past the top of
//                                              the address space are rejected
module mem_burst_writer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_aresetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] burst_len,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  mem_burst_writer_if.master    bus
);

  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_next;

  logic [ADDR_WIDTH-1:0]   base_q;
  logic [ADDR_WIDTH-1:0]   len_q;
  logic [ADDR_WIDTH-1:0]   acc_cnt;
  logic                    slot_valid;
  logic                    slot_last;
  logic [ADDR_WIDTH-1:0]   slot_addr;
  logic [DATA_WIDTH-1:0]   slot_data;
  logic [DATA_WIDTH/8-1:0] slot_strb;

  logic len_ok, range_ok, start_ok, start_bad;
  logic up_ready, up_hs, dn_hs, beat_is_last;

  assign len_ok = (burst_len != '0);

`ifdef MEM_BURST_WRITER_ADDR_WRAP_EN
  assign range_ok = 1'b1;
`else
  // One extra bit so base+len can express exactly 2^ADDR_WIDTH, which is
  // still legal (the last beat lands on the top address).
  localparam logic [ADDR_WIDTH:0] ADDR_SPAN = {1'b1, {ADDR_WIDTH{1'b0}}};
  logic [ADDR_WIDTH:0] end_addr;
  assign end_addr = {1'b0, base_addr} + {1'b0, burst_len};
  assign range_ok = (end_addr <= ADDR_SPAN);
`endif

  assign start_ok  = (state == IDLE) && start && len_ok && range_ok;
  assign start_bad = (state == IDLE) && start && !(len_ok && range_ok);

  // Upstream is accepted only while beats remain and the slot is free or
  // emptying this cycle; this also holds off any surplus upstream beats.
  assign up_ready     = (state == RUN) && (acc_cnt < len_q) &&
                        (!slot_valid || bus.m00_axis_tready);
  assign up_hs        = bus.s00_axis_tvalid && up_ready;
  assign dn_hs        = slot_valid && bus.m00_axis_tready;
  assign beat_is_last = (acc_cnt == len_q - ONE);

  // State register.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: the burst ends when the slot holding the last beat drains,
  // then DONE lasts exactly one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (dn_hs && slot_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Burst bookkeeping and the output slot. The write address is formed
  // when a beat enters the slot so the output is purely registered.
  always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
    if (!m00_axis_aresetn) begin
      err        <= 1'b0;
      base_q     <= '0;
      len_q      <= '0;
      acc_cnt    <= '0;
      slot_valid <= 1'b0;
      slot_last  <= 1'b0;
      slot_addr  <= '0;
      slot_data  <= '0;
      slot_strb  <= '0;
    end else begin
      err <= start_bad;
      if (start_ok) begin
        base_q  <= base_addr;
        len_q   <= burst_len;
        acc_cnt <= '0;
      end else if (up_hs) begin
        acc_cnt <= acc_cnt + ONE;
      end
      if (up_hs) begin
        slot_valid <= 1'b1;
        slot_last  <= beat_is_last;
        slot_addr  <= base_q + acc_cnt;
        slot_data  <= bus.s00_axis_tdata;
        slot_strb  <= bus.s00_axis_tstrb;
      end else if (dn_hs) begin
        slot_valid <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  assign bus.s00_axis_tready   = up_ready;
  assign bus.m00_axis_tvalid   = slot_valid;
  assign bus.m00_axis_wr_en    = slot_valid;
  assign bus.m00_axis_tlast    = slot_valid && slot_last;
  assign bus.m00_axis_wr_addr  = slot_addr;
  assign bus.m00_axis_wr_tdata = slot_data;
  assign bus.m00_axis_tstrb    = slot_strb;

endmodule

// File: tb/tb_mem_burst_writer.sv
// tb_mem_burst_writer
// Directed bench for mem_burst_writer. Stimulus pushes the hand-computed
// beats it expects into a queue; a monitor on the falling edge pops and
// compares every memory write handshake, checks that stalled beats hold
// still, and counts done pulses.
module tb_mem_burst_writer;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] burst_len;
  logic          busy, done, err;

  always #5 clk = ~clk;

  mem_burst_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_burst_writer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .m00_axis_aclk   (clk),
    .m00_axis_aresetn(rst_n),
    .start           (start),
    .base_addr       (base_addr),
    .burst_len       (burst_len),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .bus             (bus.master)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] strb;
    logic          last;
    logic          consec;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  int done_seen = 0;
  int done_exp = 0;
  logic        stall_prev = 1'b0;
  logic [49:0] stall_vec;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void expect_beat(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                      input logic [SW-1:0] s, input logic l, input logic c);
    beat_t b;
    b.addr = a; b.data = d; b.strb = s; b.last = l; b.consec = c;
    exp_q.push_back(b);
  endfunction

  // Monitor: compares each memory write handshake against the queue.
  always @(negedge clk) begin
    beat_t e;
    logic [49:0] cur_vec;
    cyc = cyc + 1;
    cur_vec = {bus.m00_axis_tvalid, bus.m00_axis_wr_addr, bus.m00_axis_wr_tdata,
               bus.m00_axis_tstrb, bus.m00_axis_tlast};
    if (rst_n) begin
      if (done) begin
        done_seen++;
        check_output("done_after_last_hs", 64'(cyc), 64'(last_hs_cyc + 1));
      end
      if (stall_prev) check_output("stall_hold", 64'(cur_vec), 64'(stall_vec));
      if (bus.m00_axis_tvalid) check_output("wr_en_eq_tvalid", 64'(bus.m00_axis_wr_en), 64'd1);
      if (bus.m00_axis_tvalid && !bus.m00_axis_tready) begin
        check_output("s_tready_in_stall", 64'(bus.s00_axis_tready), 64'd0);
        stall_prev = 1'b1;
        stall_vec  = cur_vec;
      end else begin
        stall_prev = 1'b0;
      end
      if (bus.m00_axis_tvalid && bus.m00_axis_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat actual addr=%0h required no beat", bus.m00_axis_wr_addr);
        end else begin
          e = exp_q.pop_front();
          check_output("beat_addr", 64'(bus.m00_axis_wr_addr), 64'(e.addr));
          check_output("beat_data", 64'(bus.m00_axis_wr_tdata), 64'(e.data));
          check_output("beat_strb", 64'(bus.m00_axis_tstrb), 64'(e.strb));
          check_output("beat_last", 64'(bus.m00_axis_tlast), 64'(e.last));
          if (e.consec) check_output("beat_consecutive", 64'(cyc), 64'(last_hs_cyc + 1));
        end
        last_hs_cyc = cyc;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic apply_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    start = 1'b1; base_addr = b; burst_len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic apply_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
    bit got = 0;
    bus.s00_axis_tvalid = 1'b1; bus.s00_axis_tdata = d; bus.s00_axis_tstrb = s;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.s00_axis_tready) begin got = 1; break; end
    end
    @(posedge clk); #1;
    bus.s00_axis_tvalid = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("[TB] FAIL send_timeout actual no s00_axis_tready required handshake data=%0h", d);
    end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; failures++;
      $display("[TB] FAIL idle_timeout actual pending=%0d busy=%0b required 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic check_reset_outputs();
    check_output("rst_busy",   64'(busy), 64'd0);
    check_output("rst_done",   64'(done), 64'd0);
    check_output("rst_err",    64'(err), 64'd0);
    check_output("rst_s_tready", 64'(bus.s00_axis_tready), 64'd0);
    check_output("rst_tvalid", 64'(bus.m00_axis_tvalid), 64'd0);
    check_output("rst_wr_en",  64'(bus.m00_axis_wr_en), 64'd0);
    check_output("rst_tlast",  64'(bus.m00_axis_tlast), 64'd0);
    check_output("rst_addr",   64'(bus.m00_axis_wr_addr), 64'd0);
    check_output("rst_data",   64'(bus.m00_axis_wr_tdata), 64'd0);
    check_output("rst_strb",   64'(bus.m00_axis_tstrb), 64'd0);
  endtask

  task automatic check_err_pulse(input string name);
    @(negedge clk);
    check_output({name, "_err"}, 64'(err), 64'd1);
    check_output({name, "_busy"}, 64'(busy), 64'd0);
    @(negedge clk);
    check_output({name, "_err_one_cycle"}, 64'(err), 64'd0);
  endtask

  initial begin
    start = 1'b0; base_addr = '0; burst_len = '0;
    bus.s00_axis_tvalid = 1'b0; bus.s00_axis_tdata = '0; bus.s00_axis_tstrb = '0;
    bus.m00_axis_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-beat burst.
    $display("[TB] single beat");
    expect_beat(12'h001, 32'h00000022, 4'hF, 1'b1, 1'b0);
    done_exp++;
    apply_start(12'h001, 12'd1);
    check_output("busy_after_start", 64'(busy), 64'd1);
    apply_beat(32'h00000022, 4'hF);
    wait_idle();

    // Four beats back-to-back at full rate.
    $display("[TB] four beats");
    expect_beat(12'h010, 32'h000000A0, 4'hF, 1'b0, 1'b0);
    expect_beat(12'h011, 32'h000000A1, 4'hF, 1'b0, 1'b1);
    expect_beat(12'h012, 32'h000000A2, 4'hF, 1'b0, 1'b1);
    expect_beat(12'h013, 32'h000000A3, 4'hF, 1'b1, 1'b1);
    done_exp++;
    apply_start(12'h010, 12'd4);
    for (int k = 0; k < 4; k++) apply_beat(32'hA0 + 32'(k), 4'hF);
    wait_idle();

    // Three beats with the memory port stalling beat 1 for three cycles.
    $display("[TB] stall");
    expect_beat(12'h020, 32'h000000B0, 4'h3, 1'b0, 1'b0);
    expect_beat(12'h021, 32'h000000B1, 4'hC, 1'b0, 1'b0);
    expect_beat(12'h022, 32'h000000B2, 4'h5, 1'b1, 1'b0);
    done_exp++;
    apply_start(12'h020, 12'd3);
    fork
      begin
        apply_beat(32'hB0, 4'h3);
        apply_beat(32'hB1, 4'hC);
        apply_beat(32'hB2, 4'h5);
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (bus.m00_axis_tvalid && bus.m00_axis_tready && bus.m00_axis_wr_addr == 12'h020) begin
            seen = 1; break;
          end
        end
        if (!seen) begin
          checks++; failures++;
          $display("[TB] FAIL stall_setup actual beat0 absent required beat0 at 020");
        end
        @(posedge clk); #1 bus.m00_axis_tready = 1'b0;
        repeat (3) @(posedge clk);
        #1 bus.m00_axis_tready = 1'b1;
      end
    join
    wait_idle();

    // Burst ending exactly at the top address is legal in both builds.
    $display("[TB] top of address space");
    expect_beat(12'hFFC, 32'h000000C0, 4'hF, 1'b0, 1'b0);
    expect_beat(12'hFFD, 32'h000000C1, 4'hF, 1'b0, 1'b1);
    expect_beat(12'hFFE, 32'h000000C2, 4'hF, 1'b0, 1'b1);
    expect_beat(12'hFFF, 32'h000000C3, 4'hF, 1'b1, 1'b1);
    done_exp++;
    apply_start(12'hFFC, 12'd4);
    for (int k = 0; k < 4; k++) apply_beat(32'hC0 + 32'(k), 4'hF);
    wait_idle();

    // Burst crossing the top address.
    $display("[TB] crossing top address");
`ifdef MEM_BURST_WRITER_ADDR_WRAP_EN
    expect_beat(12'hFFE, 32'h000000F0, 4'hF, 1'b0, 1'b0);
    expect_beat(12'hFFF, 32'h000000F1, 4'hF, 1'b0, 1'b1);
    expect_beat(12'h000, 32'h000000F2, 4'hF, 1'b0, 1'b1);
    expect_beat(12'h001, 32'h000000F3, 4'hF, 1'b1, 1'b1);
    done_exp++;
    apply_start(12'hFFE, 12'd4);
    for (int k = 0; k < 4; k++) apply_beat(32'hF0 + 32'(k), 4'hF);
    wait_idle();
`else
    apply_start(12'hFFE, 12'd4);
    check_err_pulse("wrap_reject");
`endif

    // Zero-length request.
    $display("[TB] zero length");
    apply_start(12'h050, 12'd0);
    check_err_pulse("len_zero");

    // Start during RUN is ignored; surplus upstream beats are held off.
    $display("[TB] start during run");
    expect_beat(12'h100, 32'h000000D0, 4'hF, 1'b0, 1'b0);
    expect_beat(12'h101, 32'h000000D1, 4'hF, 1'b1, 1'b1);
    done_exp++;
    apply_start(12'h100, 12'd2);
    apply_start(12'h300, 12'd1);
    check_output("run_start_no_err", 64'(err), 64'd0);
    check_output("run_start_busy", 64'(busy), 64'd1);
    apply_beat(32'hD0, 4'hF);
    apply_beat(32'hD1, 4'hF);
    bus.s00_axis_tvalid = 1'b1; bus.s00_axis_tdata = 32'h00000BAD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("surplus_held_off", 64'(bus.s00_axis_tready), 64'd0);
    end
    wait_idle();
    bus.s00_axis_tvalid = 1'b0;

    // Reset in the middle of an eight-beat burst.
    $display("[TB] reset mid-burst");
    expect_beat(12'h200, 32'h000000E0, 4'hF, 1'b0, 1'b0);
    expect_beat(12'h201, 32'h000000E1, 4'hF, 1'b0, 1'b1);
    apply_start(12'h200, 12'd8);
    apply_beat(32'hE0, 4'hF);
    apply_beat(32'hE1, 4'hF);
    @(negedge clk);
    check_output("mid_burst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("post_rst_busy", 64'(busy), 64'd0);
    check_output("post_rst_s_tready", 64'(bus.s00_axis_tready), 64'd0);
    check_output("post_rst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);

    check_output("queue_empty", 64'(exp_q.size()), 64'd0);
    check_output("done_count", 64'(done_seen), 64'(done_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_burst_writer.md
MEM_BURST_WRITER -- requirements
Module: mem_burst_writer

Interface
REQ-001 Parameter ADDR_WIDTH, default 12, memory word-address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width (multiple of 8).
REQ-003 m00_axis_aclk  in  1  single clock; all logic on rising edge.
REQ-004 m00_axis_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle burst request, sampled only in IDLE.
REQ-006 base_addr  in  ADDR_WIDTH  first write address, captured with start.
REQ-007 burst_len  in  ADDR_WIDTH  beat count, captured with start; 0 = invalid.
REQ-008 busy  out  1  high from accepted start until the final beat hands off.
REQ-009 done  out  1  one-cycle pulse after the final output handshake.
REQ-010 err  out  1  one-cycle pulse when a start is rejected.
REQ-011 s00_axis_tdata / s00_axis_tstrb / s00_axis_tvalid  in  DATA_WIDTH / DATA_WIDTH/8 / 1  upstream beat.
REQ-012 s00_axis_tready  out  1  upstream accept.
REQ-013 m00_axis_wr_en / m00_axis_wr_addr / m00_axis_wr_tdata / m00_axis_tstrb  out  1 / ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  memory write beat.
REQ-014 m00_axis_tvalid / m00_axis_tlast  out  1 / 1  beat valid, last beat of burst.
REQ-015 m00_axis_tready  in  1  memory write-port accept.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on accepted start; RUN->DONE on handshake of the beat with tlast; DONE->IDLE after exactly one cycle, done=1 during DONE.
REQ-017 Start accepted only in IDLE with burst_len!=0; start in RUN or DONE ignored with no err; start with burst_len=0 gives err pulse next cycle, state stays IDLE.
REQ-018 Output stage is a single register slot; a beat transfers on m00_axis_tvalid & m00_axis_tready.
REQ-019 s00_axis_tready = (state==RUN) & (accepted count < burst_len) & (!m00_axis_tvalid | m00_axis_tready), combinational.
REQ-020 Upstream handshake loads slot next edge: latency one cycle from s00 handshake to m00_axis_tvalid; back-to-back bursts of beats run at one beat per clock with tready held high.
REQ-021 m00_axis_wr_en equals m00_axis_tvalid; data/strb copied unmodified from upstream beat.
REQ-022 Beat k (k=0..burst_len-1) written at address base_addr+k, ADDR_WIDTH arithmetic.
REQ-023 m00_axis_tlast=1 only on beat burst_len-1; burst_len=1 gives tlast on first beat.
REQ-024 Slot contents and m00_axis_tvalid stable while m00_axis_tvalid=1 and m00_axis_tready=0.
REQ-025 Upstream s00_axis_tlast is not used; beat count alone bounds the burst; extra upstream beats are held off (tready=0).
REQ-026 busy=1 in RUN and DONE.

Reset
REQ-027 aresetn low forces IDLE immediately; busy, done, err, s00_axis_tready, m00_axis_tvalid, m00_axis_wr_en, m00_axis_tlast = 0; wr_addr, wr_tdata, tstrb = 0; counters = 0.
REQ-028 Reset mid-burst abandons the burst; no done pulse; first cycle after release is IDLE.

Configuration
REQ-029 Macro MEM_BURST_WRITER_ADDR_WRAP_EN defined: address wraps modulo 2^ADDR_WIDTH (max address followed by 0); any nonzero burst_len accepted.
REQ-030 Macro undefined: start with base_addr+burst_len > 2^ADDR_WIDTH rejected with err pulse, state stays IDLE; no wrap ever occurs.

Verification
REQ-031 base=0x001, len=1, data 0x00000022, strb=0xF, tready=1 -> one beat addr 0x001, tlast=1, done pulse one cycle after handshake.
REQ-032 base=0x010, len=4, data 0xA0..0xA3, tready=1 -> addrs 0x010..0x013 on consecutive cycles, tlast only on 0xA3.
REQ-033 len=3, m00_axis_tready low 3 cycles on beat 1 -> beat 1 held stable, s00_axis_tready=0 meanwhile, no beat lost or duplicated.
REQ-034 base=0xFFE, len=4 -> with macro: addrs 0xFFE,0xFFF,0x000,0x001; without: err pulse, busy stays 0.
REQ-035 len=0 -> err pulse; start during RUN ignored; aresetn low after beat 2 of len=8 -> all outputs 0, no done.
